// File: rtl/riego_pkg.sv
// Shared definitions for the irrigation controller: state encoding, timer width, defaults.
package riego_pkg;

  localparam int unsigned TMR_W         = 32;
  localparam int unsigned DEB_CYC_DEF   = 1_000_000;
  localparam int unsigned RIEGO_MAX_DEF = 500_000_000;
  localparam int unsigned PAUSA_CYC_DEF = 1_500_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RIEGO = 2'd1,
    PAUSA = 2'd2,
    FALLA = 2'd3
  } estado_t;

endpackage

// File: rtl/antirrebote.sv
// Two-flop synchronizer followed by a stability counter that flips the filtered
// level only after the synced input has disagreed with it for DEB_CYC cycles.
module antirrebote
  import riego_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt
);

  logic             r_meta;
  logic             r_sync;
  logic             r_filt;
  logic [TMR_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_done;

  assign w_diff = r_sync ^ r_filt;
  assign w_done = (r_cnt == TMR_W'(DEB_CYC - 1));
  assign o_filt = r_filt;

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (!w_diff) begin
      r_cnt  <= '0;
    end else if (w_done) begin
      r_cnt  <= '0;
      r_filt <= r_sync;
    end else begin
      r_cnt  <= r_cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/control_riego.sv
// Irrigation controller: filters the soil and tank sensors, runs the pump FSM
// (idle / watering / soak / fault) and drives the pump and status outputs.
module control_riego
  import riego_pkg::*;
#(
  parameter int unsigned DEB_CYC   = DEB_CYC_DEF,
  parameter int unsigned RIEGO_MAX = RIEGO_MAX_DEF,
  parameter int unsigned PAUSA_CYC = PAUSA_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       humedad,
  input  logic       MODbomba,
  input  logic       lowLevel,
  input  logic       highLevel,
  output logic       regar,
  output logic       bomba,
  output logic       tanqueVacio,
  output logic       tanqueLleno,
  output logic [1:0] estado
);

  logic             w_seco;
  logic             w_nivel;
  logic             w_lleno;
  logic             r_mod_meta;
  logic             r_mod_sync;
  estado_t          r_state;
  estado_t          w_next_state;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_next_tmr;
  logic             r_regar;
  logic             r_bomba;
  logic             r_vacio;
  logic             r_lleno;

  antirrebote #(.DEB_CYC(DEB_CYC)) u_deb_hum (
    .clk   (clk),
    .rst   (rst),
    .i_raw (humedad),
    .o_filt(w_seco)
  );

  antirrebote #(.DEB_CYC(DEB_CYC)) u_deb_low (
    .clk   (clk),
    .rst   (rst),
    .i_raw (lowLevel),
    .o_filt(w_nivel)
  );

  antirrebote #(.DEB_CYC(DEB_CYC)) u_deb_high (
    .clk   (clk),
    .rst   (rst),
    .i_raw (highLevel),
    .o_filt(w_lleno)
  );

  // Pump-module presence is only synchronized, never debounced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mod_meta <= 1'b0;
      r_mod_sync <= 1'b0;
    end else begin
      r_mod_meta <= MODbomba;
      r_mod_sync <= r_mod_meta;
    end
  end

  // State and timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_next_state;
      r_tmr   <= w_next_tmr;
    end
  end

  // Next state and timer; supply loss outranks the run-time limit, which outranks wet soil.
  always_comb begin
    w_next_state = r_state;
    w_next_tmr   = '0;
    case (r_state)
      IDLE: begin
        if (w_seco && r_mod_sync && w_nivel) begin
          w_next_state = RIEGO;
        end
      end
      RIEGO: begin
        if (!r_mod_sync || !w_nivel) begin
          w_next_state = IDLE;
        end else if (r_tmr == TMR_W'(RIEGO_MAX - 1)) begin
          w_next_state = FALLA;
        end else if (!w_seco) begin
          w_next_state = PAUSA;
        end else begin
          w_next_tmr = r_tmr + TMR_W'(1);
        end
      end
      PAUSA: begin
        if (r_tmr == TMR_W'(PAUSA_CYC - 1)) begin
          w_next_state = IDLE;
        end else begin
          w_next_tmr = r_tmr + TMR_W'(1);
        end
      end
      FALLA: begin
        if (!w_seco) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Registered outputs; the pump register tracks the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regar <= 1'b0;
      r_bomba <= 1'b0;
      r_vacio <= 1'b1;
      r_lleno <= 1'b0;
    end else begin
      r_regar <= w_seco;
      r_bomba <= (w_next_state == RIEGO);
      r_vacio <= ~w_nivel;
      r_lleno <= w_lleno;
    end
  end

  assign regar       = r_regar;
  assign bomba       = r_bomba;
  assign tanqueVacio = r_vacio;
  assign tanqueLleno = r_lleno;
  assign estado      = r_state;

endmodule

// File: tb/tb_control_riego.sv
// Scoreboard bench for control_riego with a history-based reference model.
module tb_control_riego;

  localparam int DEB  = 4;
  localparam int RMAX = 20;
  localparam int PCYC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       humedad;
  logic       MODbomba;
  logic       lowLevel;
  logic       highLevel;
  logic       regar;
  logic       bomba;
  logic       tanqueVacio;
  logic       tanqueLleno;
  logic [1:0] estado;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       regar;
    logic       bomba;
    logic       tv;
    logic       tl;
    logic [1:0] est;
  } exp_t;

  exp_t exp_q[$];

  control_riego #(.DEB_CYC(DEB), .RIEGO_MAX(RMAX), .PAUSA_CYC(PCYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .humedad    (humedad),
    .MODbomba   (MODbomba),
    .lowLevel   (lowLevel),
    .highLevel  (highLevel),
    .regar      (regar),
    .bomba      (bomba),
    .tanqueVacio(tanqueVacio),
    .tanqueLleno(tanqueLleno),
    .estado     (estado)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw input histories (newest at the back) stand in for the synchronizers.
  int   qh[$], ql[$], qhi[$], qm[$];
  int   fh, fl, fhi, st, dwell;
  int   seco, nivel, mod_ok, nst;
  exp_t e;

  // A filtered level flips once the DEB most recent synced samples all disagree with it.
  function automatic int settle(input int q[$], input int filt);
    for (int j = 0; j < DEB; j++)
      if (q[q.size() - 2 - j] == filt) return filt;
    return 1 - filt;
  endfunction

  task automatic model_reset();
    qh.delete(); ql.delete(); qhi.delete(); qm.delete();
    for (int i = 0; i < DEB + 2; i++) begin
      qh.push_back(0); ql.push_back(0); qhi.push_back(0); qm.push_back(0);
    end
    fh = 0; fl = 0; fhi = 0; st = 0; dwell = 0;
  endtask

  // Model advances on every clock edge; an asynchronous reset discards pending expectations.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      exp_q.delete();
      e = '{regar: 1'b0, bomba: 1'b0, tv: 1'b1, tl: 1'b0, est: 2'd0};
      exp_q.push_back(e);
    end else begin
      seco   = fh;
      nivel  = fl;
      mod_ok = qm[qm.size() - 2];
      nst    = st;
      case (st)
        0: if (seco == 1 && mod_ok == 1 && nivel == 1) nst = 1;
        1: begin
          if (mod_ok == 0 || nivel == 0) nst = 0;
          else if (dwell == RMAX - 1)    nst = 3;
          else if (seco == 0)            nst = 2;
        end
        2: if (dwell == PCYC - 1) nst = 0;
        default: if (seco == 0) nst = 0;
      endcase
      e.regar = 1'(fh);
      e.tv    = 1'(1 - fl);
      e.tl    = 1'(fhi);
      e.bomba = (nst == 1);
      e.est   = 2'(nst);
      fh  = settle(qh, fh);
      fl  = settle(ql, fl);
      fhi = settle(qhi, fhi);
      dwell = (nst == st) ? dwell + 1 : 0;
      st    = nst;
      qh.push_back(int'(humedad));   void'(qh.pop_front());
      ql.push_back(int'(lowLevel));  void'(ql.pop_front());
      qhi.push_back(int'(highLevel)); void'(qhi.pop_front());
      qm.push_back(int'(MODbomba));  void'(qm.pop_front());
      exp_q.push_back(e);
    end
  end

  // Monitor: outputs are presented every cycle; compare each against the queued expectation.
  exp_t m;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      chk1("sb_regar", regar, m.regar);
      chk1("sb_bomba", bomba, m.bomba);
      chk1("sb_tanqueVacio", tanqueVacio, m.tv);
      chk1("sb_tanqueLleno", tanqueLleno, m.tl);
      chk2("sb_estado", estado, m.est);
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("rst_async_bomba", bomba, 1'b0);
    chk1("rst_async_regar", regar, 1'b0);
    chk1("rst_async_vacio", tanqueVacio, 1'b1);
    chk1("rst_async_lleno", tanqueLleno, 1'b0);
    chk2("rst_async_estado", estado, 2'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
  endtask

  int sel;

  initial begin
    rst = 1'b1; humedad = 1'b0; MODbomba = 1'b0; lowLevel = 1'b0; highLevel = 1'b0;
    hold(3);
    chk1("reset_bomba", bomba, 1'b0);
    chk1("reset_vacio", tanqueVacio, 1'b1);
    chk2("reset_estado", estado, 2'd0);
    rst = 1'b0;

    // Wet soil, pump present, tank above low mark: settle in IDLE.
    MODbomba = 1'b1; lowLevel = 1'b1; highLevel = 1'b1;
    hold(20);
    chk1("idle_vacio", tanqueVacio, 1'b0);
    chk1("idle_lleno", tanqueLleno, 1'b1);

    // Soil dries: regar and pump on the 7th edge after the raw change.
    humedad = 1'b1;
    repeat (6) @(posedge clk);
    #2 chk1("dry_regar_edge6", regar, 1'b0);
    @(posedge clk);
    #2;
    chk1("dry_regar_edge7", regar, 1'b1);
    chk1("dry_bomba_edge7", bomba, 1'b1);
    chk2("dry_estado_edge7", estado, 2'd1);

    // Soil stays dry past the run limit: fault, then recover on wet soil.
    hold(30);
    chk2("fault_estado", estado, 2'd3);
    chk1("fault_bomba", bomba, 1'b0);
    humedad = 1'b0;
    hold(15);
    chk2("fault_exit_estado", estado, 2'd0);

    // Normal watering ending in a soak period.
    humedad = 1'b1;
    hold(12);
    humedad = 1'b0;
    hold(25);
    chk2("soak_done_estado", estado, 2'd0);

    // Tank runs low while watering.
    humedad = 1'b1;
    hold(12);
    lowLevel = 1'b0;
    hold(10);
    chk1("low_vacio", tanqueVacio, 1'b1);
    chk1("low_bomba", bomba, 1'b0);
    chk2("low_estado", estado, 2'd0);
    chk1("low_regar", regar, 1'b1);
    lowLevel = 1'b1;
    humedad  = 1'b0;
    hold(30);

    // Short humidity glitch is ignored.
    humedad = 1'b1;
    hold(3);
    humedad = 1'b0;
    hold(10);
    chk1("glitch_regar", regar, 1'b0);

    // Dry soil without pump module.
    MODbomba = 1'b0;
    humedad  = 1'b1;
    hold(12);
    chk1("nomod_regar", regar, 1'b1);
    chk1("nomod_bomba", bomba, 1'b0);

    // Pump module returns, watering starts, then reset mid-watering.
    MODbomba = 1'b1;
    hold(10);
    chk1("prereset_bomba", bomba, 1'b1);
    rst_pulse();
    humedad = 1'b0;
    hold(10);

    // Randomized phase: inputs held for random durations, occasional resets.
    for (int it = 0; it < 400; it++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: humedad   = 1'($urandom_range(0, 1));
        4, 5:       lowLevel  = ($urandom_range(0, 3) != 0);
        6:          highLevel = 1'($urandom_range(0, 1));
        7:          MODbomba  = ($urandom_range(0, 4) != 0);
        default:    humedad   = ~humedad;
      endcase
      if ($urandom_range(0, 99) == 0) rst_pulse();
      hold(int'($urandom_range(1, 28)));
    end
    hold(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
